// File: rtl/sev_seg_mux_ctrl.sv
// Two-digit multiplexed seven-segment controller with glitch-free commit of loaded digit pairs.
// Define SEV_SEG_DEADTIME_EN to add blanking states (DEAD0/DEAD1) between lit digits.
module sev_seg_mux_ctrl #(
  parameter int REFRESH_CYCLES = 24000
`ifdef SEV_SEG_DEADTIME_EN
  , parameter int DEAD_CYCLES = 16
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic       load,
  output logic [3:0] s,
  output logic       an0,
  output logic       an1,
  output logic       pending
);

  localparam logic [15:0] REF_LAST = 16'(REFRESH_CYCLES - 1);
`ifdef SEV_SEG_DEADTIME_EN
  localparam logic [15:0] DEAD_LAST = 16'(DEAD_CYCLES - 1);
  typedef enum logic [1:0] {SHOW0, DEAD0, SHOW1, DEAD1} state_t;
`else
  typedef enum logic {SHOW0, SHOW1} state_t;
`endif

  state_t      state_q, state_d, nxt;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  disp0_q, disp0_d, disp1_q, disp1_d;
  logic [3:0]  pend0_q, pend0_d, pend1_q, pend1_d;
  logic        pending_q, pending_d;
  logic [3:0]  s_q, s_d;
  logic        an0_q, an0_d, an1_q, an1_d;
  logic        last, commit;

  always_comb begin
    last   = 1'b0;
    nxt    = state_q;
    commit = 1'b0;
`ifdef SEV_SEG_DEADTIME_EN
    unique case (state_q)
      SHOW0: begin last = (cnt_q == REF_LAST);  nxt = DEAD0; end
      DEAD0: begin last = (cnt_q == DEAD_LAST); nxt = SHOW1; end
      SHOW1: begin last = (cnt_q == REF_LAST);  nxt = DEAD1; end
      DEAD1: begin last = (cnt_q == DEAD_LAST); nxt = SHOW0; end
    endcase
    // Only blanking boundaries may change display contents.
    commit = last && (nxt == DEAD0 || nxt == DEAD1);
`else
    last   = (cnt_q == REF_LAST);
    nxt    = (state_q == SHOW0) ? SHOW1 : SHOW0;
    commit = last;
`endif
    state_d = last ? nxt : state_q;
    cnt_d   = last ? 16'd0 : cnt_q + 16'd1;

    disp0_d = disp0_q;
    disp1_d = disp1_q;
    if (commit && pending_q) begin
      disp0_d = pend0_q;
      disp1_d = pend1_q;
    end

    pend0_d   = pend0_q;
    pend1_d   = pend1_q;
    pending_d = pending_q;
    if (load) begin
      pend0_d   = digit0;
      pend1_d   = digit1;
      pending_d = 1'b1;
    end else if (commit) begin
      pending_d = 1'b0;
    end

    // Outputs are computed from next-cycle state so they register alongside it.
`ifdef SEV_SEG_DEADTIME_EN
    s_d = (state_d == SHOW0 || state_d == DEAD1) ? disp0_d : disp1_d;
`else
    s_d = (state_d == SHOW0) ? disp0_d : disp1_d;
`endif
    an0_d = (state_d != SHOW0);
    an1_d = (state_d != SHOW1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SHOW0;
      cnt_q     <= 16'd0;
      disp0_q   <= 4'd0;
      disp1_q   <= 4'd0;
      pend0_q   <= 4'd0;
      pend1_q   <= 4'd0;
      pending_q <= 1'b0;
      s_q       <= 4'd0;
      an0_q     <= 1'b0;
      an1_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      disp0_q   <= disp0_d;
      disp1_q   <= disp1_d;
      pend0_q   <= pend0_d;
      pend1_q   <= pend1_d;
      pending_q <= pending_d;
      s_q       <= s_d;
      an0_q     <= an0_d;
      an1_q     <= an1_d;
    end
  end

  assign s       = s_q;
  assign an0     = an0_q;
  assign an1     = an1_q;
  assign pending = pending_q;

endmodule

// File: tb/tb_sev_seg_mux_ctrl.sv
// Randomized self-checking bench for sev_seg_mux_ctrl; reference model tracks position in the refresh period.
module tb_sev_seg_mux_ctrl;
  localparam int R = 4;
`ifdef SEV_SEG_DEADTIME_EN
  localparam int D = 2;
  localparam bit DEADEN = 1'b1;
  localparam int P = 2 * (R + D);
`else
  localparam int D = 0;
  localparam bit DEADEN = 1'b0;
  localparam int P = 2 * R;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0, load = 1'b0;
  logic [3:0] digit0 = 4'd0, digit1 = 4'd0;
  logic [3:0] s;
  logic an0, an1, pending;

  int errors = 0;
  int checks = 0;

  // model state
  int       mpos = 0;
  logic [3:0] md0 = 0, md1 = 0, mp0 = 0, mp1 = 0;
  bit       mpend = 0;

  always #5 clk = ~clk;

`ifdef SEV_SEG_DEADTIME_EN
  sev_seg_mux_ctrl #(.REFRESH_CYCLES(R), .DEAD_CYCLES(D)) dut (
`else
  sev_seg_mux_ctrl #(.REFRESH_CYCLES(R)) dut (
`endif
    .clk(clk), .reset(reset), .digit0(digit0), .digit1(digit1), .load(load),
    .s(s), .an0(an0), .an1(an1), .pending(pending));

  // expected {s, an0, an1, pending} from position in the period
  function automatic logic [6:0] exp_vec();
    logic show0, show1, sel0;
    show0 = (mpos < R);
    show1 = DEADEN ? (mpos >= R + D && mpos < 2 * R + D) : (mpos >= R);
    sel0  = DEADEN ? (mpos < R || mpos >= 2 * R + D) : show0;
    return {sel0 ? md0 : md1, !show0, !show1, mpend};
  endfunction

  task automatic step(input bit rst, input bit ld, input logic [3:0] d0, input logic [3:0] d1);
    int  npos;
    bit  commit;
    reset = rst; load = ld; digit0 = d0; digit1 = d1;
    @(posedge clk);
    if (rst) begin
      mpos = 0; md0 = 0; md1 = 0; mp0 = 0; mp1 = 0; mpend = 0;
    end else begin
      npos   = (mpos + 1) % P;
      commit = DEADEN ? (npos == R || npos == 2 * R + D) : (npos == 0 || npos == R);
      if (commit && mpend) begin md0 = mp0; md1 = mp1; end
      if (ld) begin mp0 = d0; mp1 = d1; mpend = 1; end
      else if (commit) mpend = 0;
      mpos = npos;
    end
    #1;
    reset = 1'b0; load = 1'b0;
  endtask

  task automatic advance_to(input int target);
    for (int i = 0; i < P && mpos != target; i++) step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    step(1, 1, 4'hF, 4'hF);
    step(1, 0, 0, 0);
    checks++;
    if ({s, an0, an1, pending} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: got s=%h an0=%b an1=%b pend=%b, want s=0 an0=0 an1=1 pend=0", s, an0, an1, pending);
    end
  endtask

  task automatic test_idle_pattern();
    for (int i = 0; i < 2 * P; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if ({s, an0, an1, pending} !== exp_vec() || s !== 4'h0) begin
        errors++;
        $display("FAIL idle_pattern cyc %0d: got %b want %b", i, {s, an0, an1, pending}, exp_vec());
      end
    end
  endtask

  task automatic test_load_commit();
    advance_to(1);
    step(0, 1, 4'h3, 4'hA);
    checks++;
    if (pending !== 1'b1) begin
      errors++;
      $display("FAIL load_pending: got %b want 1", pending);
    end
    for (int i = 0; i < P + 2; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if ({s, an0, an1, pending} !== exp_vec()) begin
        errors++;
        $display("FAIL load_commit cyc %0d pos %0d: got %b want %b", i, mpos, {s, an0, an1, pending}, exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    bit seen_old;
    advance_to(1);
    step(0, 1, 4'h1, 4'h2);
    step(0, 1, 4'h5, 4'h6);
    seen_old = 0;
    for (int i = 0; i < P + 2; i++) begin
      step(0, 0, 0, 0);
      if (s == 4'h1 || s == 4'h2) seen_old = 1;
      checks++;
      if ({s, an0, an1, pending} !== exp_vec()) begin
        errors++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", i, {s, an0, an1, pending}, exp_vec());
      end
    end
    checks++;
    if (seen_old) begin
      errors++;
      $display("FAIL back_to_back_stale: overwritten pair 1/2 displayed, want only 5/6");
    end
  endtask

  task automatic test_load_on_commit_edge();
    advance_to(1);
    step(0, 1, 4'h1, 4'h2);
    advance_to(R - 1);
    step(0, 1, 4'h7, 4'h8);
    checks++;
    if ({s, pending} !== {4'h2, 1'b1}) begin
      errors++;
      $display("FAIL commit_edge_load: got s=%h pend=%b want s=2 pend=1", s, pending);
    end
    for (int i = 0; i < P + 2; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if ({s, an0, an1, pending} !== exp_vec()) begin
        errors++;
        $display("FAIL commit_edge cyc %0d: got %b want %b", i, {s, an0, an1, pending}, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    advance_to(DEADEN ? R + D : R);
    step(0, 1, 4'h9, 4'hC);
    step(1, 0, 0, 0);
    checks++;
    if ({s, an0, an1, pending} !== {4'h0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got s=%h an0=%b an1=%b pend=%b want 0/0/1/0", s, an0, an1, pending);
    end
    for (int i = 0; i < P; i++) begin
      step(0, 0, 0, 0);
      checks++;
      if ({s, an0, an1, pending} !== exp_vec() || s !== 4'h0) begin
        errors++;
        $display("FAIL reset_mid_after cyc %0d: got %b want %b", i, {s, an0, an1, pending}, exp_vec());
      end
    end
  endtask

  task automatic test_random();
    bit rst, ld;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 63) == 0);
      ld  = ($urandom_range(0, 3) == 0);
      step(rst, ld, 4'($urandom), 4'($urandom));
      checks++;
      if ({s, an0, an1, pending} !== exp_vec() || (an0 === 1'b0 && an1 === 1'b0)) begin
        errors++;
        $display("FAIL random cyc %0d pos %0d: got %b want %b", i, mpos, {s, an0, an1, pending}, exp_vec());
      end
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_idle_pattern();
    test_load_commit();
    test_back_to_back();
    test_load_on_commit_edge();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
